bsg_counter_clear_up_down: RTL and testbench
============================================

BSG_COUNTER_CLEAR_UP_DOWN -- requirements
Module: bsg_counter_clear_up_down

Interface
REQ-001 SHALL have parameter width_p, default 24, count register width in bits.
REQ-002 SHALL have parameter max_val_p, default 2^width_p-1, largest legal count value; 1 <= max_val_p <= 2^width_p-1.
REQ-003 SHALL have parameter init_val_p, default 0, value loaded by reset and by clear_i; init_val_p <= max_val_p.
REQ-004 SHALL have parameter max_step_p, default 1, largest per-cycle increment or decrement; 1 <= max_step_p <= max_val_p.
REQ-005 SHALL have parameter saturate_p, default 0, where 0 selects wrap-around and 1 selects saturation at 0 and max_val_p.
REQ-006 SHALL define step width sw = $clog2(max_step_p+1).
REQ-007 clk_i  input  1  single clock; all state updates on rising edge.
REQ-008 reset_n_i  input  1  reset is synchronous and active-low.
REQ-009 clear_i  input  1  reload init_val_p before applying this cycle's up/down.
REQ-010 up_i  input  sw  increment amount this cycle; values > max_step_p are illegal.
REQ-011 down_i  input  sw  decrement amount this cycle; values > max_step_p are illegal.
REQ-012 count_o  output  width_p  registered count.
REQ-013 zero_o  output  1  combinational, count_o == 0.
REQ-014 max_o  output  1  combinational, count_o == max_val_p.
REQ-015 wrap_o  output  1  registered over/underflow event flag.

Function
REQ-016 SHALL compute base = clear_i ? init_val_p : count_o, then sum = base + up_i - down_i, in width_p+2-bit signed arithmetic with no truncation.
REQ-017 With saturate_p=0, sum > max_val_p SHALL load sum-(max_val_p+1), sum < 0 SHALL load sum+(max_val_p+1), and any other sum SHALL load sum.
REQ-018 With saturate_p=1, sum > max_val_p SHALL load max_val_p, sum < 0 SHALL load 0, and any other sum SHALL load sum.
REQ-019 wrap_o SHALL be set on the cycle after any clock edge where sum fell outside [0, max_val_p], in either mode.
REQ-020 up_i and down_i SHALL both apply when nonzero in the same cycle, and equal amounts SHALL leave base unchanged with no wrap event.
REQ-021 clear_i with up_i=down_i=0 SHALL load init_val_p one cycle later.
REQ-022 clear_i with up_i=1 and init_val_p=0 SHALL load 1, matching the existing clear-then-count semantics.
REQ-023 Count latency SHALL be exactly one cycle from input sampling to count_o update; there is no enable and no handshake.
REQ-024 Illegal step values SHALL trigger a simulation-only assertion, and the synthesized result for them is unspecified.

Reset
REQ-025 When reset_n_i is low at a clock edge, count_o SHALL load init_val_p and wrap_o SHALL load 0, regardless of clear_i, up_i and down_i.
REQ-026 Reset SHALL dominate clear_i, and deassertion mid-stream SHALL resume counting from init_val_p on the first edge where reset_n_i is high.

Configuration
REQ-027 Macro BSG_COUNTER_CLEAR_UP_DOWN_STICKY_WRAP_EN SHALL control wrap_o behaviour.
REQ-028 When the macro is defined, wrap_o SHALL be sticky: it sets on an event and holds until clear_i or reset.
REQ-029 When the macro is defined and clear_i coincides with a new event, wrap_o SHALL be 1.
REQ-030 When the macro is undefined, wrap_o SHALL be a one-cycle pulse per event.

Verification
REQ-031 width_p=4, max_val_p=9, saturate_p=0: count 9 with up_i=1 -> count_o=0, wrap_o=1 next cycle; with the macro undefined, wrap_o=0 the following idle cycle.
REQ-032 Same config: count 0 with down_i=1 -> count_o=9, wrap_o=1; with max_step_p=3 and count 1, down_i=3 -> count_o=8.
REQ-033 saturate_p=1, max_val_p=9: count 8 with up_i=3 -> count_o=9, max_o=1, wrap_o=1; count 0 with down_i=2 -> count_o=0, zero_o=1.
REQ-034 init_val_p=5: count 7 with clear_i=1, up_i=2, down_i=0 -> count_o=7; clear_i=1, up_i=0, down_i=0 -> count_o=5.
REQ-035 Run at count 3 with reset_n_i=0 plus clear_i=1 and up_i=1 -> count_o=init_val_p, wrap_o=0; first cycle after reset_n_i=1 with up_i=1 -> count_o=init_val_p+1.
REQ-036 With the macro defined: wrap event, then 5 idle cycles -> wrap_o stays 1; clear_i -> wrap_o=0 next cycle.

Source files
------------

// File: rtl/bsg_counter_clear_up_down.sv
// Up/down counter with synchronous clear, optional saturation and a registered over/underflow flag.
// Define BSG_COUNTER_CLEAR_UP_DOWN_STICKY_WRAP_EN to make wrap_o sticky until clear_i or reset.
module bsg_counter_clear_up_down #(
  parameter int width_p    = 24,
  parameter int max_val_p  = (1 << width_p) - 1,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  parameter int saturate_p = 0,
  localparam int sw        = $clog2(max_step_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic [sw-1:0]      up_i,
  input  logic [sw-1:0]      down_i,
  output logic [width_p-1:0] count_o,
  output logic               zero_o,
  output logic               max_o,
  output logic               wrap_o
);

  // Two guard bits keep base + up - down exact without truncation.
  localparam int sum_w = width_p + 2;
  localparam logic signed [sum_w-1:0] max_s  = sum_w'(max_val_p);
  localparam logic signed [sum_w-1:0] mod_s  = sum_w'(longint'(max_val_p) + 64'sd1);
  localparam logic [width_p-1:0]      max_l  = width_p'(max_val_p);
  localparam logic [width_p-1:0]      init_l = width_p'(init_val_p);
  localparam logic [sw-1:0]           step_l = sw'(max_step_p);

  logic [width_p-1:0]      base;
  logic signed [sum_w-1:0] sum;
  logic [width_p-1:0]      count_next;
  logic                    wrap_event;
  logic                    wrap_next;

  function automatic logic [width_p-1:0] wrap_fn(input logic signed [sum_w-1:0] s);
    logic signed [sum_w-1:0] r;
    if (s > max_s)         r = s - mod_s;
    else if (s[sum_w-1])   r = s + mod_s;
    else                   r = s;
    return r[width_p-1:0];
  endfunction

  function automatic logic [width_p-1:0] sat_fn(input logic signed [sum_w-1:0] s);
    logic [width_p-1:0] r;
    if (s > max_s)         r = max_l;
    else if (s[sum_w-1])   r = '0;
    else                   r = s[width_p-1:0];
    return r;
  endfunction

  always_comb begin
    base       = clear_i ? init_l : count_o;
    sum        = $signed({2'b00, base})
               + $signed({{(sum_w-sw){1'b0}}, up_i})
               - $signed({{(sum_w-sw){1'b0}}, down_i});
    wrap_event = (sum > max_s) || sum[sum_w-1];
    count_next = (saturate_p != 0) ? sat_fn(sum) : wrap_fn(sum);
`ifdef BSG_COUNTER_CLEAR_UP_DOWN_STICKY_WRAP_EN
    wrap_next  = wrap_event || (wrap_o && !clear_i);
`else
    wrap_next  = wrap_event;
`endif
  end

  // p0: count and wrap registers, one cycle after input sampling
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_o <= init_l;
      wrap_o  <= 1'b0;
    end else begin
      count_o <= count_next;
      wrap_o  <= wrap_next;
    end
  end

  assign zero_o = (count_o == '0);
  assign max_o  = (count_o == max_l);

  assert property (@(posedge clk_i) disable iff (!reset_n_i) (up_i <= step_l) && (down_i <= step_l));

endmodule

// File: tb/tb_bsg_counter_clear_up_down.sv
// Scoreboard bench: two counters (wrap mode init 5, saturate mode init 0) driven by shared directed vectors.
module tb_bsg_counter_clear_up_down;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] up = '0;
  logic [1:0] down = '0;

  logic [3:0] count_w, count_s;
  logic       zero_w, max_w, wrap_w;
  logic       zero_s, max_s, wrap_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cw;
    logic       ww;
    logic [3:0] cs;
    logic       ws;
  } exp_t;

  exp_t q[$];
  logic sticky_w = 1'b0;
  logic sticky_s = 1'b0;

  always #5 clk = ~clk;

  bsg_counter_clear_up_down #(
    .width_p(4), .max_val_p(9), .init_val_p(5), .max_step_p(3), .saturate_p(0)
  ) dut_w (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .up_i(up), .down_i(down),
    .count_o(count_w), .zero_o(zero_w), .max_o(max_w), .wrap_o(wrap_w)
  );

  bsg_counter_clear_up_down #(
    .width_p(4), .max_val_p(9), .init_val_p(0), .max_step_p(3), .saturate_p(1)
  ) dut_s (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .up_i(up), .down_i(down),
    .count_o(count_s), .zero_o(zero_s), .max_o(max_s), .wrap_o(wrap_s)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Drive one vector after the falling edge and queue the hand-computed result
  // (count and wrap event) expected after the next rising edge.
  task automatic vec(input logic r, input logic c, input logic [1:0] u, input logic [1:0] d,
                     input logic [3:0] cw, input logic ew, input logic [3:0] cs, input logic es);
    exp_t e;
    @(negedge clk);
    reset_n = r; clear = c; up = u; down = d;
`ifdef BSG_COUNTER_CLEAR_UP_DOWN_STICKY_WRAP_EN
    sticky_w = r && (ew || (sticky_w && !c));
    sticky_s = r && (es || (sticky_s && !c));
`else
    sticky_w = r && ew;
    sticky_s = r && es;
`endif
    e.cw = cw; e.ww = sticky_w; e.cs = cs; e.ws = sticky_s;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("count_w", 32'(count_w), 32'(e.cw));
      cmp("zero_w",  32'(zero_w),  32'(e.cw == 4'd0));
      cmp("max_w",   32'(max_w),   32'(e.cw == 4'd9));
      cmp("wrap_w",  32'(wrap_w),  32'(e.ww));
      cmp("count_s", 32'(count_s), 32'(e.cs));
      cmp("zero_s",  32'(zero_s),  32'(e.cs == 4'd0));
      cmp("max_s",   32'(max_s),   32'(e.cs == 4'd9));
      cmp("wrap_s",  32'(wrap_s),  32'(e.ws));
    end
  end

  initial begin
    //   rst clr up dn    cw ew   cs es
    vec(0, 1, 1, 0,   5, 0,   0, 0);  // reset dominates clear and up
    vec(1, 0, 1, 0,   6, 0,   1, 0);
    vec(1, 0, 3, 0,   9, 0,   4, 0);
    vec(1, 0, 1, 0,   0, 1,   5, 0);  // 9+1 wraps to 0
    vec(1, 0, 0, 0,   0, 0,   5, 0);
    vec(1, 0, 0, 1,   9, 1,   4, 0);  // 0-1 wraps to 9
    vec(1, 0, 0, 0,   9, 0,   4, 0);
    vec(1, 0, 1, 3,   7, 0,   2, 0);
    vec(1, 0, 2, 2,   7, 0,   2, 0);  // equal up/down
    vec(1, 0, 0, 3,   4, 0,   0, 1);  // saturate at 0
    vec(1, 0, 0, 3,   1, 0,   0, 1);
    vec(1, 0, 0, 3,   8, 1,   0, 1);  // 1-3 wraps to 8
    vec(1, 0, 3, 0,   1, 1,   3, 0);
    vec(1, 0, 3, 0,   4, 0,   6, 0);
    vec(1, 0, 2, 0,   6, 0,   8, 0);
    vec(1, 0, 3, 0,   9, 0,   9, 1);  // 8+3 saturates at 9
    vec(1, 0, 3, 0,   2, 1,   9, 1);
    vec(1, 0, 3, 0,   5, 0,   9, 1);
    vec(1, 0, 2, 0,   7, 0,   9, 1);
    vec(1, 1, 2, 0,   7, 0,   2, 0);  // clear then +2
    vec(1, 1, 0, 0,   5, 0,   0, 0);  // plain clear
    vec(1, 1, 1, 0,   6, 0,   1, 0);  // clear then +1
    vec(1, 1, 0, 1,   4, 0,   0, 1);  // clear coincides with event
    vec(1, 0, 0, 0,   4, 0,   0, 0);
    vec(1, 0, 0, 1,   3, 0,   0, 1);
    vec(0, 1, 1, 0,   5, 0,   0, 0);  // mid-stream reset
    vec(1, 0, 1, 0,   6, 0,   1, 0);  // resume from init
    vec(1, 0, 3, 0,   9, 0,   4, 0);
    vec(1, 0, 1, 0,   0, 1,   5, 0);
    for (int i = 0; i < 5; i++) vec(1, 0, 0, 0,   0, 0,   5, 0);
    vec(1, 1, 0, 0,   5, 0,   0, 0);
    vec(1, 0, 0, 0,   5, 0,   0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
